// File: rtl/obuf_pkg.sv
// Shared constants and types for the output capture buffer.
// Register offsets are Avalon word addresses.
package obuf_pkg;

    localparam logic [5:0] OBUF_DATA_BASE = 6'h00;
    localparam logic [5:0] OBUF_CNT_BASE  = 6'h10;
    localparam logic [5:0] OBUF_DROP_BASE = 6'h20;
    localparam logic [5:0] OBUF_TIME      = 6'h30;
    localparam logic [5:0] OBUF_STATUS    = 6'h31;
    localparam logic [5:0] OBUF_CFG       = 6'h32;

    typedef logic [31:0] port_word_t;

    localparam port_word_t OBUF_EMPTY_WORD = 32'h0000_00FF;

endpackage

// File: rtl/obuf_port_fifo.sv
// One circular capture FIFO: pointers, occupancy, flags, drop counter and
// sticky overflow/underflow bits around a simple dual-port RAM.
module obuf_port_fifo #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4096,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic [31:0]       drop_cnt,
    output logic              ovf,
    output logic              udf
);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;
    logic             wr_ok;
    logic             ram_we;
    logic [CNT_W-1:0] cnt_next;

    // A pop on a full FIFO frees the slot the same-cycle write lands in.
    always_comb begin
        pop_ok   = pop & ~empty;
        wr_ok    = wr_en & (~full | pop_ok);
        ram_we   = wr_ok & ~clear;
        cnt_next = count + CNT_W'(wr_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            drop_cnt <= '0;
            ovf      <= 1'b0;
            udf      <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= cnt_next;
            full  <= (cnt_next == CNT_W'(DEPTH));
            empty <= (cnt_next == '0);
            if (wr_en && !wr_ok) begin
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
                ovf <= 1'b1;
            end
            if (pop && empty) begin
                udf <= 1'b1;
            end
        end
    end

    obuf_sdp_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(PTR_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(wr_ptr),
        .wdata(wr_data),
        .raddr(rd_ptr),
        .rdata(rd_data)
    );

endmodule

// File: rtl/obuf_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A same-address read and write return the old contents.
module obuf_sdp_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/output_capture_buffer.sv
// Per-output-port capture FIFOs drained over an Avalon-MM slave.
// Every read returns its word two cycles after the read strobe rises.
module output_capture_buffer
    import obuf_pkg::*;
#(
    parameter int                NUM_PORTS  = 4,
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 4096,
    parameter logic [DATA_W-1:0] EMPTY_WORD = DATA_W'(OBUF_EMPTY_WORD)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        chipselect,
    input  logic                        read,
    input  logic [5:0]                  address,
    input  logic [NUM_PORTS*DATA_W-1:0] wr_data,
    input  logic [NUM_PORTS-1:0]        wr_en,
    input  logic [NUM_PORTS-1:0]        clear,
    input  logic [31:0]                 total_time,
    output logic [DATA_W-1:0]           readdata,
    output logic                        readdatavalid,
    output logic [NUM_PORTS-1:0]        full,
    output logic [NUM_PORTS-1:0]        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0]    fifo_q    [NUM_PORTS];
    logic [CNT_W-1:0]     fifo_cnt  [NUM_PORTS];
    logic [31:0]          fifo_drop [NUM_PORTS];
    logic [NUM_PORTS-1:0] pop;
    logic [NUM_PORTS-1:0] ovf;
    logic [NUM_PORTS-1:0] udf;

    logic              prev_rd;
    logic              read_start;
    logic              is_pop;
    logic              pop_empty;
    logic [3:0]        port_sel;
    logic [DATA_W-1:0] reg_val;
    logic [DATA_W-1:0] pop_q;

    logic              s1_valid;
    logic              s1_pop;
    logic              s1_empty;
    logic [3:0]        s1_port;
    logic [DATA_W-1:0] s1_val;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        obuf_port_fifo #(
            .DATA_W(DATA_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .clear   (clear[p]),
            .wr_en   (wr_en[p]),
            .wr_data (wr_data[p*DATA_W +: DATA_W]),
            .pop     (pop[p]),
            .rd_data (fifo_q[p]),
            .count   (fifo_cnt[p]),
            .full    (full[p]),
            .empty   (empty[p]),
            .drop_cnt(fifo_drop[p]),
            .ovf     (ovf[p]),
            .udf     (udf[p])
        );
    end

    // Register values are captured at the strobe so non-pop reads see
    // pre-cycle state, matching what a pop observes.
    always_comb begin
        read_start = chipselect & read & ~prev_rd;
        pop        = '0;
        is_pop     = 1'b0;
        pop_empty  = 1'b0;
        port_sel   = '0;
        reg_val    = EMPTY_WORD;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (address == OBUF_DATA_BASE + 6'(p)) begin
                pop[p]    = read_start;
                is_pop    = 1'b1;
                pop_empty = empty[p];
                port_sel  = 4'(p);
            end
            if (address == OBUF_CNT_BASE + 6'(p)) begin
                reg_val = DATA_W'(fifo_cnt[p]);
            end
            if (address == OBUF_DROP_BASE + 6'(p)) begin
                reg_val = DATA_W'(fifo_drop[p]);
            end
        end
        if (address == OBUF_TIME) begin
            reg_val = DATA_W'(total_time);
        end
        if (address == OBUF_STATUS) begin
            reg_val = DATA_W'({16'(udf), 16'(ovf)});
        end
        if (address == OBUF_CFG) begin
            reg_val = DATA_W'({16'h0000, 8'(NUM_PORTS), 8'(PTR_W)});
        end
    end

    always_comb begin
        pop_q = EMPTY_WORD;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (s1_port == 4'(p)) begin
                pop_q = fifo_q[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_rd       <= 1'b0;
            s1_valid      <= 1'b0;
            s1_pop        <= 1'b0;
            s1_empty      <= 1'b0;
            s1_port       <= '0;
            s1_val        <= '0;
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            prev_rd       <= chipselect & read;
            s1_valid      <= read_start;
            s1_pop        <= is_pop;
            s1_empty      <= pop_empty;
            s1_port       <= port_sel;
            s1_val        <= reg_val;
            readdatavalid <= s1_valid;
            if (s1_valid) begin
                readdata <= s1_pop ? (s1_empty ? EMPTY_WORD : pop_q) : s1_val;
            end
        end
    end

endmodule

// File: tb/tb_output_capture_buffer.sv
// Randomised and directed bench for output_capture_buffer (4 ports, depth 8)
// against a queue-based model of the capture FIFOs and register map.
module tb_output_capture_buffer;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int DP = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           chipselect = 1'b0;
    logic           read = 1'b0;
    logic [5:0]     address = '0;
    logic [127:0]   wr_data = '0;
    logic [3:0]     wr_en = '0;
    logic [3:0]     clear = '0;
    logic [31:0]    total_time = '0;
    logic [31:0]    readdata;
    logic           readdatavalid;
    logic [3:0]     full;
    logic [3:0]     empty;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    logic [31:0] mq [NP][$];
    int unsigned mdrop [NP];
    logic [3:0]  movf, mudf;
    logic        m_prev;
    logic        st_v, st_dc, exp_v, exp_dc;
    logic [31:0] st_d, exp_d;
    logic [31:0] got_q [$];

    output_capture_buffer #(
        .NUM_PORTS(NP),
        .DATA_W   (DW),
        .DEPTH    (DP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .chipselect   (chipselect),
        .read         (read),
        .address      (address),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .clear        (clear),
        .total_time   (total_time),
        .readdata     (readdata),
        .readdatavalid(readdatavalid),
        .full         (full),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        for (int p = 0; p < NP; p++) begin
            mq[p].delete();
            mdrop[p] = 0;
        end
        movf = '0; mudf = '0; m_prev = 1'b0;
        st_v = 1'b0; st_dc = 1'b0; st_d = '0;
        exp_v = 1'b0; exp_dc = 1'b0; exp_d = '0;
    endfunction

    // One bus cycle: drive inputs, advance the model, check the read port.
    task automatic bus_cycle(input logic [3:0] we, input logic [127:0] wd,
                             input logic rd, input logic [5:0] addr,
                             input logic [3:0] clr);
        logic        rs, dc;
        logic [31:0] val;
        int          a;
        wr_en = we; wr_data = wd; chipselect = rd; read = rd;
        address = addr; clear = clr; total_time = $urandom;
        a  = int'(addr);
        rs = rd && !m_prev;
        m_prev = rd;
        dc = 1'b0;
        val = 32'h0000_00FF;
        if (rs) begin
            if (a < NP) begin
                if (mq[a].size() > 0) val = mq[a][0];
                if (clr[a]) dc = 1'b1;
            end else if (a >= 16 && a < 16 + NP) begin
                val = mq[a-16].size();
            end else if (a >= 32 && a < 32 + NP) begin
                val = mdrop[a-32];
            end else if (a == 48) begin
                val = total_time;
            end else if (a == 49) begin
                val = {12'h0, mudf, 12'h0, movf};
            end else if (a == 50) begin
                val = 32'h0000_0403;
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (clr[p]) begin
                mq[p].delete(); mdrop[p] = 0; movf[p] = 1'b0; mudf[p] = 1'b0;
                continue;
            end
            if (rs && a == p) begin
                if (mq[p].size() > 0) void'(mq[p].pop_front());
                else mudf[p] = 1'b1;
            end
            if (we[p]) begin
                if (mq[p].size() < DP) mq[p].push_back(wd[p*32 +: 32]);
                else begin
                    if (mdrop[p] != 32'hFFFF_FFFF) mdrop[p]++;
                    movf[p] = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
        exp_v = st_v; exp_d = st_d; exp_dc = st_dc;
        st_v = rs; st_d = val; st_dc = dc;
        n_tests++;
        if (readdatavalid !== exp_v) begin
            n_fail++;
            $display("FAIL readdatavalid: got %b expected %b", readdatavalid, exp_v);
        end
        if (exp_v && !exp_dc) begin
            n_tests++;
            if (readdata !== exp_d) begin
                n_fail++;
                $display("FAIL readdata: got %h expected %h (addr pipeline)", readdata, exp_d);
            end
        end
        if (readdatavalid === 1'b1) got_q.push_back(readdata);
    endtask

    task automatic idle();
        bus_cycle('0, '0, 1'b0, '0, '0);
    endtask

    task automatic write_word(input int p, input logic [31:0] d);
        logic [127:0] wd;
        wd = '0;
        wd[p*32 +: 32] = d;
        bus_cycle(4'(1 << p), wd, 1'b0, '0, '0);
    endtask

    task automatic pop_word(input int p);
        bus_cycle('0, '0, 1'b1, 6'(p), '0);
        idle();
    endtask

    task automatic read_reg(input logic [5:0] addr, output logic [31:0] v);
        got_q.delete();
        bus_cycle('0, '0, 1'b1, addr, '0);
        idle();
        v = (got_q.size() == 1) ? got_q[0] : 32'hxxxx_xxxx;
    endtask

    task automatic do_reset();
        reset = 1'b1; wr_en = '0; clear = '0; chipselect = 1'b0; read = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (readdata !== 32'h0 || readdatavalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: got %h/%b expected 0/0", readdata, readdatavalid);
        end
        n_tests++;
        if (empty !== 4'hF || full !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_flags: got empty=%h full=%h expected F/0", empty, full);
        end
    endtask

    task automatic test_pop_sequence();
        logic [31:0] v;
        do_reset();
        write_word(2, 32'hA0); write_word(2, 32'hA1); write_word(2, 32'hA2);
        got_q.delete();
        for (int i = 0; i < 4; i++) pop_word(2);
        n_tests++;
        if (got_q.size() != 4 || got_q[0] !== 32'hA0 || got_q[1] !== 32'hA1 ||
            got_q[2] !== 32'hA2 || got_q[3] !== 32'hFF) begin
            n_fail++;
            $display("FAIL pop_seq: got %0d words expected A0,A1,A2,FF", got_q.size());
        end
        read_reg(6'h31, v);
        n_tests++;
        if (v[18] !== 1'b1) begin
            n_fail++;
            $display("FAIL udf_bit18: got %h expected bit18 set", v);
        end
    endtask

    task automatic test_held_read();
        logic [31:0] w0, v;
        do_reset();
        w0 = $urandom;
        write_word(0, w0); write_word(0, $urandom);
        got_q.delete();
        for (int i = 0; i < 5; i++) bus_cycle('0, '0, 1'b1, 6'h00, '0);
        idle(); idle();
        n_tests++;
        if (got_q.size() != 1 || got_q[0] !== w0) begin
            n_fail++;
            $display("FAIL held_read: got %0d pulses expected 1 with %h", got_q.size(), w0);
        end
        read_reg(6'h10, v);
        n_tests++;
        if (v !== 32'd1) begin
            n_fail++;
            $display("FAIL held_count: got %h expected 1", v);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] w [10];
        logic [31:0] v;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            w[i] = $urandom;
            write_word(0, w[i]);
        end
        n_tests++;
        if (full[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_full: got %b expected 1", full[0]);
        end
        read_reg(6'h20, v);
        n_tests++;
        if (v !== 32'd2) begin
            n_fail++;
            $display("FAIL ovf_drop: got %h expected 2", v);
        end
        read_reg(6'h31, v);
        n_tests++;
        if (v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_bit0: got %h expected bit0 set", v);
        end
        got_q.delete();
        for (int i = 0; i < 8; i++) pop_word(0);
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (i >= got_q.size() || got_q[i] !== w[i]) begin
                n_fail++;
                $display("FAIL ovf_data%0d: got %h expected %h", i,
                         (i < got_q.size()) ? got_q[i] : 32'hx, w[i]);
            end
        end
        n_tests++;
        if (empty[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_empty: got %b expected 1", empty[0]);
        end
    endtask

    task automatic test_full_simul();
        logic [31:0] w0, v;
        logic [127:0] wd;
        do_reset();
        w0 = $urandom;
        write_word(1, w0);
        for (int i = 1; i < 8; i++) write_word(1, $urandom);
        wd = '0; wd[63:32] = $urandom;
        got_q.delete();
        bus_cycle(4'b0010, wd, 1'b1, 6'h01, '0);
        idle();
        n_tests++;
        if (got_q.size() != 1 || got_q[0] !== w0) begin
            n_fail++;
            $display("FAIL simul_pop: got %0d words expected oldest %h", got_q.size(), w0);
        end
        read_reg(6'h11, v);
        n_tests++;
        if (v !== 32'd8) begin
            n_fail++;
            $display("FAIL simul_count: got %h expected 8", v);
        end
        read_reg(6'h21, v);
        n_tests++;
        if (v !== 32'd0) begin
            n_fail++;
            $display("FAIL simul_drop: got %h expected 0", v);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] w [20];
        logic [31:0] v;
        do_reset();
        got_q.delete();
        for (int i = 0; i < 20; i++) begin
            w[i] = $urandom;
            write_word(3, w[i]);
            n_tests++;
            if (empty[3] !== 1'b0 || full[3] !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_flags%0d: got e=%b f=%b expected 0/0", i, empty[3], full[3]);
            end
            bus_cycle('0, '0, 1'b1, 6'h03, '0);
        end
        idle(); idle();
        for (int i = 0; i < 20; i++) begin
            n_tests++;
            if (i >= got_q.size() || got_q[i] !== w[i]) begin
                n_fail++;
                $display("FAIL wrap_data%0d: got %h expected %h", i,
                         (i < got_q.size()) ? got_q[i] : 32'hx, w[i]);
            end
        end
        read_reg(6'h31, v);
        n_tests++;
        if (v[3] !== 1'b0 || v[19] !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_status: got %h expected bits 3,19 clear", v);
        end
    endtask

    task automatic test_clear();
        logic [31:0] v;
        logic [127:0] wd;
        do_reset();
        pop_word(0);
        for (int i = 0; i < 9; i++) write_word(0, $urandom);
        for (int i = 0; i < 3; i++) pop_word(0);
        wd = '0; wd[31:0] = $urandom;
        bus_cycle(4'b0001, wd, 1'b0, '0, 4'b0001);
        n_tests++;
        if (empty[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_empty: got %b expected 1", empty[0]);
        end
        read_reg(6'h10, v);
        n_tests++;
        if (v !== 32'd0) begin
            n_fail++;
            $display("FAIL clr_count: got %h expected 0", v);
        end
        read_reg(6'h20, v);
        n_tests++;
        if (v !== 32'd0) begin
            n_fail++;
            $display("FAIL clr_drop: got %h expected 0", v);
        end
        read_reg(6'h31, v);
        n_tests++;
        if (v[0] !== 1'b0 || v[16] !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_status: got %h expected bits 0,16 clear", v);
        end
        write_word(0, 32'hC0DE_0001);
        read_reg(6'h00, v);
        n_tests++;
        if (v !== 32'hC0DE_0001) begin
            n_fail++;
            $display("FAIL clr_next: got %h expected C0DE0001", v);
        end
    endtask

    task automatic test_reset_pending();
        write_word(1, $urandom);
        bus_cycle('0, '0, 1'b1, 6'h01, '0);
        reset = 1'b1; chipselect = 1'b0; read = 1'b0; wr_en = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            reset = 1'b0;
            n_tests++;
            if (readdatavalid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_pending%0d: got %b expected 0", i, readdatavalid);
            end
        end
        model_reset();
    endtask

    task automatic test_random();
        logic [5:0] addrs [16];
        logic [127:0] wd;
        logic [3:0] we, clr, mfull, mempty;
        addrs = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h10, 6'h12, 6'h13,
                  6'h14, 6'h20, 6'h23, 6'h30, 6'h31, 6'h32, 6'h33, 6'h3F};
        do_reset();
        for (int c = 0; c < 400; c++) begin
            wd = {$urandom, $urandom, $urandom, $urandom};
            we = 4'($urandom);
            clr = '0;
            for (int p = 0; p < NP; p++) if ($urandom_range(40) == 0) clr[p] = 1'b1;
            bus_cycle(we, wd, $urandom_range(2) == 0, addrs[$urandom_range(15)], clr);
            for (int p = 0; p < NP; p++) begin
                mfull[p]  = (mq[p].size() == DP);
                mempty[p] = (mq[p].size() == 0);
            end
            n_tests++;
            if (full !== mfull || empty !== mempty) begin
                n_fail++;
                $display("FAIL rand_flags c%0d: got f=%h e=%h expected f=%h e=%h",
                         c, full, empty, mfull, mempty);
            end
        end
        idle(); idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_pop_sequence();
        test_held_read();
        test_overflow();
        test_full_simul();
        test_wrap();
        test_clear();
        test_reset_pending();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/output_capture_buffer.md
Name: output_capture_buffer

Overview:
Parametrised successor to the switch output-port capture RAMs. It holds one independent circular FIFO per output port. Each FIFO is filled by the scheduler's per-port write strobes and drained by the HPS over an Avalon-MM slave, one word per read transaction. It adds occupancy tracking, overflow and underflow detection, drop counting and per-port clear, which the fixed 4-port design lacked.

Parameters:
NUM_PORTS, 4, number of output ports/FIFOs (1..16)
DATA_W, 32, width of captured word and readdata
DEPTH, 4096, words per FIFO; must be a power of 2
CNT_W, $clog2(DEPTH)+1, width of occupancy counters (derived, not overridable)
EMPTY_WORD, 32'h0000_00FF, readdata returned for a pop from an empty FIFO and for unmapped addresses

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
chipselect  in  1  Avalon slave select
read  in  1  Avalon read strobe; may be held for several cycles per transaction
address  in  6  Avalon word address (map in Behaviour)
wr_data  in  NUM_PORTS x DATA_W  per-port captured word from scheduler
wr_en  in  NUM_PORTS  per-port write strobe; one word written per cycle high
clear  in  NUM_PORTS  per-port synchronous FIFO flush
total_time  in  32  scheduler cycle counter, passed through to the register map
readdata  out  DATA_W  registered read data
readdatavalid  out  1  one-cycle pulse when readdata is valid
full  out  NUM_PORTS  per-port full flag
empty  out  NUM_PORTS  per-port empty flag

Behaviour:
- Reset: all pointers, counts, drop counters and sticky bits go to 0. readdata=0, readdatavalid=0, empty=all 1s, full=0. Reset overrides every other input.
- Write, per port p: when wr_en[p]=1 and the FIFO is not full, write wr_data[p] at wr_ptr and increment wr_ptr modulo DEPTH. There is no one-cycle write deferral.
- Write when full: the word is dropped and pointers are unchanged. drop_cnt[p] increments, saturating at 0xFFFF_FFFF, and ovf[p] is set sticky.
- Read start: read_start = chipselect & read & ~prev_rd, where prev_rd is a registered copy of (chipselect & read). Only read_start acts; a held read never pops twice.
- Pop: read_start with address 0x00+p (p<NUM_PORTS) on a non-empty FIFO increments rd_ptr. The word at the old rd_ptr is returned.
- Pop when empty: no pointer change, readdata=EMPTY_WORD, udf[p] set sticky.
- Latency: for read_start in cycle T, readdata and readdatavalid=1 are presented in cycle T+2. Registered RAM read in T+1, output register in T+2. Applies to every address.
- Register map:
  - 0x00+p: pop port p
  - 0x10+p: occupancy count[p], zero-extended
  - 0x20+p: drop_cnt[p]
  - 0x30: total_time
  - 0x31: status, bits[15:0]=ovf, bits[31:16]=udf
  - 0x32: {NUM_PORTS, DEPTH log2} as [15:8],[7:0]
  - any other address, including 0x00+p with p>=NUM_PORTS: EMPTY_WORD
- Non-pop addresses are side-effect free.
- Flags: count[p] = number of words held, 0..DEPTH. full[p] = (count==DEPTH), empty[p] = (count==0), both registered with count.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap DEPTH-1 to 0 naturally. count distinguishes full from empty.
- Simultaneous write and pop, same port, same cycle:
  - non-empty and not full: both occur, count unchanged.
  - full: pop frees a slot, so the write is accepted and there is no drop.
  - empty: the pop underflows (it sees pre-cycle state) and the write is accepted, giving count=1.
- Clear: clear[p] zeroes rd_ptr, wr_ptr, count, drop_cnt, ovf[p] and udf[p]. Clear beats a same-cycle write or pop on that port. An in-flight pop of that port still completes its readdata pulse, with undefined data.
- Reset mid-transaction: a pending readdatavalid is cancelled.

Decomposition:
- Package obuf_pkg holds:
  - register offsets: OBUF_DATA_BASE=6'h00, OBUF_CNT_BASE=6'h10, OBUF_DROP_BASE=6'h20, OBUF_TIME=6'h30, OBUF_STATUS=6'h31, OBUF_CFG=6'h32
  - default EMPTY_WORD
  - typedef port_word_t for the DATA_W-wide array element
- One sub-module, obuf_port_fifo. It holds the pointers, count, flags, drop counter and sticky bits, and instantiates the existing simple dual-port RAM. It is generated NUM_PORTS times.
- The top level contains read_start detection, address decode and the readdata pipeline.

Test Plan:
- Reset, then write 3 words 0xA0,0xA1,0xA2 on port 2, then pop 0x02 three times -> readdata 0xA0,0xA1,0xA2 each at T+2 with one readdatavalid pulse each; a 4th pop -> 0xFF and status bit 18 set.
- Hold read high for 5 cycles at address 0x00 with 2 words queued -> exactly one pop; read 0x10 -> 1.
- DEPTH=8: write 10 words on port 0 -> full[0]=1, 0x20 reads 2, status bit0=1; pop all 8 -> values are words 0..7 and empty[0]=1.
- Full port 1 with wr_en and pop in the same cycle -> no drop, count stays 8, popped word is the oldest.
- Wrap: DEPTH=8, 20 interleaved write/pop pairs on port 3 -> data in order, count never exceeds 1, no ovf or udf.
- clear[0] pulsed with wr_en[0]=1 and 5 words queued -> count 0, drop_cnt 0, ovf/udf cleared, the clear-cycle word is discarded. Assert reset during a pending pop -> no readdatavalid.
